// File: rtl/hazard_controller.sv
// hazard_controller: forwarding select, stall/flush control and memory-wait FSM.
// Optional feature macro: HAZARD_FORWARDING_EN (undefined = interlock-only build).
module hazard_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  Rs1E,
    input  logic [4:0]  Rs2E,
    input  logic [4:0]  RdE,
    input  logic [4:0]  RdM,
    input  logic [4:0]  RdW,
    input  logic        RegWriteE,
    input  logic        RegWriteM,
    input  logic        RegWriteW,
    input  logic [1:0]  ResultSrcE,
    input  logic        PCSrcE,
    input  logic        MemAccessM,
    input  logic        mem_ready,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushD,
    output logic        FlushE,
    output logic [1:0]  ForwardA_E,
    output logic [1:0]  ForwardB_E,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
    output logic        mem_timeout
);

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic [3:0]  r_wait_cnt;
    logic [3:0]  w_wait_cnt_next;
    logic        r_timeout;
    logic        r_lu_hold;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic        w_lu_match;
    logic        w_load_use;
    logic        w_data_haz;
    logic        w_dec_stall;
    logic        w_mem_stall;
    logic        w_lu_applied;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;

    // Load in Execute feeding a Decode source; x0 never matches since RdE != 0.
    // r_lu_hold suppresses a second stall cycle for the same load.
    always_comb begin
        w_lu_match = (ResultSrcE == 2'b01) && (RdE != 5'd0)
                     && ((RdE == Rs1D) || (RdE == Rs2D));
        w_load_use = w_lu_match && !r_lu_hold;
    end

`ifdef HAZARD_FORWARDING_EN
    // Per-operand bypass select, Memory stage wins over Writeback.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        w_data_haz = 1'b0;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))
            w_fwd_a = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E))
            w_fwd_a = 2'b01;
        if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))
            w_fwd_b = 2'b10;
        else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E))
            w_fwd_b = 2'b01;
    end
`else
    logic w_unused;
    assign w_unused = ^{Rs1E, Rs2E, RdW, RegWriteW};

    // No bypass: interlock Decode until producers in E and M have drained;
    // Writeback is covered by register-file write-through.
    always_comb begin
        w_fwd_a = 2'b00;
        w_fwd_b = 2'b00;
        w_data_haz = 1'b0;
        if (RegWriteE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D)))
            w_data_haz = 1'b1;
        if (RegWriteM && (RdM != 5'd0) && ((RdM == Rs1D) || (RdM == Rs2D)))
            w_data_haz = 1'b1;
    end
`endif

    // Memory stall covers the entry cycle and every waiting cycle; the cycle
    // in which mem_ready arrives releases the pipeline and lets deferred
    // branch/load-use actions through.
    always_comb begin
        w_dec_stall  = w_load_use || w_data_haz;
        w_mem_stall  = !mem_ready && ((r_state == MEM_WAIT) || MemAccessM);
        w_lu_applied = reset && !w_mem_stall && !PCSrcE && w_load_use;
    end

    // Prioritised stall/flush/forward outputs, all forced low during reset.
    always_comb begin
        StallF     = 1'b0;
        StallD     = 1'b0;
        StallE     = 1'b0;
        StallM     = 1'b0;
        FlushD     = 1'b0;
        FlushE     = 1'b0;
        ForwardA_E = 2'b00;
        ForwardB_E = 2'b00;
        if (reset) begin
            ForwardA_E = w_fwd_a;
            ForwardB_E = w_fwd_b;
            if (w_mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
            end else if (PCSrcE) begin
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (w_dec_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    // FSM next state and saturating wait counter.
    always_comb begin
        w_state_next    = r_state;
        w_wait_cnt_next = 4'd0;
        unique case (r_state)
            RUN: begin
                if (MemAccessM && !mem_ready)
                    w_state_next = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (r_wait_cnt != 4'd15)
                    w_wait_cnt_next = r_wait_cnt + 4'd1;
                else
                    w_wait_cnt_next = r_wait_cnt;
                if (mem_ready)
                    w_state_next = RUN;
            end
            default: w_state_next = RUN;
        endcase
    end

    // State, wait counter, sticky timeout, load-use hold and event counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_wait_cnt  <= 4'd0;
            r_timeout   <= 1'b0;
            r_lu_hold   <= 1'b0;
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_next;
            r_wait_cnt <= w_wait_cnt_next;
            if ((r_state == MEM_WAIT) && (w_wait_cnt_next == 4'd15))
                r_timeout <= 1'b1;
            r_lu_hold <= w_lu_applied;
            if (StallF && (r_stall_cnt != 16'hFFFF))
                r_stall_cnt <= r_stall_cnt + 16'd1;
            if (FlushD && (r_flush_cnt != 16'hFFFF))
                r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign stall_count = r_stall_cnt;
    assign flush_count = r_flush_cnt;
    assign mem_timeout = r_timeout;

endmodule
